// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants up to NUM_CDB requesting execute units per cycle
// in round-robin order and registers the granted writeback packets onto the CDB lanes.
package cdb_pkg;
    parameter int unsigned RESULT_W = 32;
    parameter int unsigned TAG_W    = 6;

    typedef struct packed {
        logic [RESULT_W-1:0] result;
        logic [TAG_W-1:0]    dest_tag;
        logic                is_valid;
    } writeback_packet_t;
endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned NUM_FU  = 4,
    parameter int unsigned NUM_CDB = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  writeback_packet_t fu_result [NUM_FU],
    output logic [NUM_FU-1:0] fu_gnt,
    output writeback_packet_t cdb_out [NUM_CDB]
);
    localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PTR_W-1:0]  rr_ptr_q;
    logic [PTR_W-1:0]  rr_ptr_d;
    logic [NUM_FU-1:0] gnt;
    writeback_packet_t cdb_q [NUM_CDB];
    writeback_packet_t cdb_d [NUM_CDB];

    always_comb begin
        int unsigned cnt;
        cnt      = 0;
        gnt      = '0;
        rr_ptr_d = rr_ptr_q;
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            cdb_d[k] = '0;
        end
        // Scan position j maps to unit (rr_ptr + j) mod NUM_FU; the k-th winner takes lane k.
        for (int unsigned j = 0; j < NUM_FU; j++) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (i == (32'(rr_ptr_q) + j) % NUM_FU && fu_result[i].is_valid
                    && !flush && cnt < NUM_CDB) begin
                    gnt[i] = 1'b1;
                    for (int unsigned k = 0; k < NUM_CDB; k++) begin
                        if (k == cnt) begin
                            cdb_d[k]          = fu_result[i];
                            cdb_d[k].is_valid = 1'b1;
                        end
                    end
                    cnt      = cnt + 1;
                    rr_ptr_d = PTR_W'((i + 1) % NUM_FU);
                end
            end
        end
    end

    assign fu_gnt  = rst ? '0 : gnt;
    assign cdb_out = cdb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            for (int unsigned k = 0; k < NUM_CDB; k++) begin
                cdb_q[k] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int unsigned k = 0; k < NUM_CDB; k++) begin
                cdb_q[k] <= cdb_d[k];
            end
        end
    end
endmodule
